debug_monitor: RTL and testbench

//   Run/step/breakpoint controller plus multi-channel decimal display for the CPU.

---
 rtl/debug_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_debug_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_monitor.sv
// Run/step/breakpoint controller for the CPU clock-enable, plus a
// double-dabble decimal display of one selectable debug channel.
module debug_monitor #(
    parameter int DIVISOR    = 50_000_000,
    parameter int VAL_WIDTH  = 6,
    parameter int NUM_CH     = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode_run,
    input  logic                          step,
    input  logic                          bp_en,
    input  logic [VAL_WIDTH-1:0]          bp_addr,
    input  logic [VAL_WIDTH-1:0]          pc,
    input  logic [NUM_CH*VAL_WIDTH-1:0]   ch_data,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic                          cpu_ce,
    output logic                          halted,
    output logic                          conv_done,
    output logic [7*NUM_DIGITS-1:0]       hex
);

    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BCD_DIG = (VAL_WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int EXT_DIG = (BCD_DIG > NUM_DIGITS) ? BCD_DIG : NUM_DIGITS;
    localparam int EXT_W   = 4 * EXT_DIG;
    localparam int IT_W    = $clog2(VAL_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
    localparam logic [IT_W-1:0]  IT_LAST = IT_W'(VAL_WIDTH - 1);
    localparam logic [6:0]       SEG_DASH = 7'b0111111;

    // ---------------- run / step / breakpoint ----------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_ce;
    logic             r_halted;
    logic             r_step_q;
    logic             r_chk;

    logic             w_step_edge;
    logic             w_bp_hit;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ce_nxt;
    logic             w_halt_nxt;

    assign w_step_edge = step & ~r_step_q;
    assign w_bp_hit    = r_chk & bp_en & (pc == bp_addr);
    assign w_tick      = mode_run & (r_cnt == CNT_MAX);

    // A breakpoint hit wins over a run pulse due in the same cycle.
    always_comb begin
        w_cnt_nxt  = '0;
        w_ce_nxt   = 1'b0;
        w_halt_nxt = r_halted;
        unique case (1'b1)
            r_halted & w_step_edge: begin
                w_ce_nxt   = 1'b1;
                w_halt_nxt = 1'b0;
            end
            r_halted & ~w_step_edge: begin
                w_halt_nxt = bp_en;
            end
            ~r_halted & w_bp_hit: begin
                w_halt_nxt = 1'b1;
            end
            ~r_halted & ~w_bp_hit & mode_run: begin
                w_ce_nxt  = w_tick;
                w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
            end
            ~r_halted & ~w_bp_hit & ~mode_run: begin
                w_ce_nxt = w_step_edge;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_ce     <= 1'b0;
            r_halted <= 1'b0;
            r_step_q <= 1'b0;
            r_chk    <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ce     <= w_ce_nxt;
            r_halted <= w_halt_nxt;
            r_step_q <= step;
            r_chk    <= r_ce;
        end
    end

    assign cpu_ce = r_ce;
    assign halted = r_halted;

    // ---------------- display converter ----------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    conv_state_t r_state;
    conv_state_t w_state_nxt;

    logic [VAL_WIDTH-1:0]    r_sh;
    logic [BCD_W-1:0]        r_bcd;
    logic [IT_W-1:0]         r_it;
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic                    r_conv_done;

    logic [VAL_WIDTH-1:0]    w_ch;
    logic [BCD_W-1:0]        w_adj;
    logic [EXT_W-1:0]        w_bcd_ext;
    logic                    w_ovf;
    logic [7*NUM_DIGITS-1:0] w_hex_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        w_ch = ch_data[0 +: VAL_WIDTH];
        for (int k = 1; k < NUM_CH; k++) begin
            if (ch_sel == SEL_W'(k))
                w_ch = ch_data[k*VAL_WIDTH +: VAL_WIDTH];
        end
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd_ext = EXT_W'(r_bcd);

    // Any nonzero digit beyond the visible ones means the value won't fit.
    always_comb begin
        w_ovf     = |(w_bcd_ext >> (4 * NUM_DIGITS));
        w_hex_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hex_nxt[7*i +: 7] = w_ovf ? SEG_DASH
                                        : seg7(w_bcd_ext[4*i +: 4]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_it == IT_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh        <= '0;
            r_bcd       <= '0;
            r_it        <= '0;
            r_hex       <= '1;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sh  <= w_ch;
                    r_bcd <= '0;
                    r_it  <= '0;
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_sh[VAL_WIDTH-1]};
                    r_sh  <= {r_sh[VAL_WIDTH-2:0], 1'b0};
                    r_it  <= r_it + 1'b1;
                end
                S_DONE: begin
                    r_hex       <= w_hex_nxt;
                    r_conv_done <= 1'b1;
                end
                default: begin
                    r_it <= '0;
                end
            endcase
        end
    end

    assign hex       = r_hex;
    assign conv_done = r_conv_done;

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor: run/step timing, breakpoints,
// display conversion, overflow, channel fallback and reset.
module tb_debug_monitor;

    localparam int VW = 6;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SD = 7'b0111111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_run;
    logic          step;
    logic          bp_en;
    logic [VW-1:0] bp_addr;
    logic [VW-1:0] pc;
    logic [4*VW-1:0] ch_data;
    logic [1:0]    ch_sel;
    logic          cpu_ce;
    logic          halted;
    logic          conv_done;
    logic [13:0]   hex;

    logic [3*VW-1:0] ch_data1;
    logic [1:0]    ch_sel1;
    logic          cpu_ce1;
    logic          halted1;
    logic          conv_done1;
    logic [6:0]    hex1;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc, nce, nce1, ndone;
    int f_ce, f_dn, k5, kh, at1, at2, base;
    logic [13:0] hex_pre;
    logic        saw_halt;

    always #5 clk = ~clk;

    debug_monitor #(
        .DIVISOR(4), .VAL_WIDTH(VW), .NUM_CH(4), .NUM_DIGITS(2)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .mode_run(mode_run), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .ch_data(ch_data), .ch_sel(ch_sel), .cpu_ce(cpu_ce),
        .halted(halted), .conv_done(conv_done), .hex(hex)
    );

    debug_monitor #(
        .DIVISOR(1), .VAL_WIDTH(VW), .NUM_CH(3), .NUM_DIGITS(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .mode_run(1'b1), .step(1'b0),
        .bp_en(1'b0), .bp_addr(6'd0), .pc(6'd0),
        .ch_data(ch_data1), .ch_sel(ch_sel1), .cpu_ce(cpu_ce1),
        .halted(halted1), .conv_done(conv_done1), .hex(hex1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // One clock; the bench plays the CPU and advances pc on each cpu_ce.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cpu_ce) begin
            pc = pc + 1'b1;
            nce++;
        end
        if (cpu_ce1) nce1++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        nce = 0;
        nce1 = 0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (conv_done) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_run = 1'b1;
        step     = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = '0;
        pc       = '0;
        ch_data  = {6'd63, 6'd42, 6'd13, 6'd7};
        ch_sel   = 2'd2;
        ch_data1 = {6'd63, 6'd10, 6'd8};
        ch_sel1  = 2'd2;
        cyc = 0; nce = 0; nce1 = 0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_ce", cpu_ce, 0);
        check("rst_halt", halted, 0);
        check("rst_done", conv_done, 0);
        check("rst_hex", hex, 14'h3FFF);
        check("rst_ce1", cpu_ce1, 0);
        check("rst_hex1", hex1, 7'h7F);
        rst_n = 1'b1;

        // run-mode period, first conversion, DIVISOR=1, overflow
        f_ce = -1; f_dn = -1; ndone = 0; hex_pre = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (cpu_ce && f_ce < 0) f_ce = cyc;
            if (conv_done) begin
                ndone++;
                if (f_dn < 0) f_dn = cyc;
            end
            if (cyc == 7) hex_pre = hex;
        end
        check("run_first_ce", f_ce, 4);
        check("run_ce_cnt", nce, 4);
        check("div1_ce_cnt", nce1, 16);
        check("hex_hold", hex_pre, 14'h3FFF);
        check("conv_first", f_dn, 8);
        check("conv_cnt", ndone, 2);
        check("hex_42", hex, {S4, S2});
        check("hex1_ovf63", hex1, SD);

        // channel changes picked up within two conversions
        ch_sel = 2'd3;
        ch_sel1 = 2'd3;
        wait_done(at1);
        wait_done(at2);
        check("conv_period", at2 - at1, 8);
        check("hex_63", hex, {S6, S3});
        check("hex1_sel_oob", hex1, S8);
        ch_sel = 2'd0;
        ch_sel1 = 2'd1;
        wait_done(at1);
        wait_done(at2);
        check("hex_07", hex, {S0, S7});
        check("hex1_ovf10", hex1, SD);

        // single step: held level gives one pulse per rising edge
        mode_run = 1'b0;
        pc = '0;
        do_reset();
        repeat (3) tick();
        check("step_idle", nce, 0);
        step = 1'b1;
        tick();
        check("step1_ce", cpu_ce, 1);
        repeat (9) tick();
        step = 1'b0;
        repeat (3) tick();
        step = 1'b1;
        tick();
        check("step2_ce", cpu_ce, 1);
        repeat (5) tick();
        check("step_cnt", nce, 2);
        step = 1'b0;

        // breakpoint at pc=5 in run mode, then step off it
        mode_run = 1'b1;
        bp_en = 1'b1;
        bp_addr = 6'd5;
        pc = '0;
        do_reset();
        k5 = -1; kh = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (nce == 5 && k5 < 0) k5 = cyc;
            if (halted) begin
                kh = cyc;
                break;
            end
        end
        check("bp_pc5_cyc", k5, 20);
        check("bp_halt_cyc", kh, 22);
        check("bp_pc", pc, 5);
        base = nce;
        repeat (10) tick();
        check("bp_no_ce", nce - base, 0);
        check("bp_hold", halted, 1);
        step = 1'b1;
        tick();
        check("bp_step_ce", cpu_ce, 1);
        check("bp_step_clr", halted, 0);
        saw_halt = 1'b0;
        repeat (6) begin
            tick();
            if (halted) saw_halt = 1'b1;
        end
        check("bp_no_rehalt", saw_halt, 0);
        check("bp_resume_pc", pc, 7);
        step = 1'b0;

        // halt again, then reset in the middle of a conversion
        bp_addr = pc + 1'b1;
        saw_halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) begin
                saw_halt = 1'b1;
                break;
            end
        end
        check("pre_rst_halt", saw_halt, 1);
        wait_done(at1);
        repeat (3) tick();
        rst_n = 1'b0;
        pc = '0;
        bp_addr = '0;
        tick();
        check("mid_rst_hex", hex, 14'h3FFF);
        check("mid_rst_ce", cpu_ce, 0);
        check("mid_rst_halt", halted, 0);
        check("mid_rst_ce1", cpu_ce1, 0);
        check("mid_rst_hex1", hex1, 7'h7F);
        rst_n = 1'b1;
        cyc = 0;
        nce = 0;
        tick();
        check("bp_rst_pc", halted, 1);
        wait_done(at1);
        check("rst_conv_at", at1, 8);
        check("bp_rst_no_ce", nce, 0);
        check("rst_hex_07", hex, {S0, S7});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
